// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the trailing checksum state).
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_CSUM,
`endif
    ST_DONE,
    ST_ERR
  } loader_state_t;

  // Byte address of instruction word idx; wraps naturally at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes MSB first into a 32-bit word.
// Used for both the length header and the instruction words.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_last
);

  logic [31:0] shift_reg;
  logic [1:0]  byte_cnt;

  // The completed word includes the byte being accepted this cycle.
  assign word      = {shift_reg[23:0], byte_data};
  assign word_last = byte_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Shift in accepted bytes; the counter wraps back to 0 after each word.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      shift_reg <= '0;
      byte_cnt  <= '0;
    end else if (byte_en) begin
      shift_reg <= word;
      byte_cnt  <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes the words
// into CPU instruction memory, holding the CPU in reset until loading ends.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        start,
  output logic        init_en,
  output logic [31:0] init_data,
  output logic [31:0] init_addr,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  loader_state_t    state;
  logic [IDX_W-1:0] word_count;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] next_idx;
  logic             accept;
  logic             asm_en;
  logic             restart;
  logic [31:0]      asm_word;
  logic             asm_last;

  assign accept   = byte_valid && byte_ready;
  assign asm_en   = accept && (state == ST_HDR || state == ST_DATA);
  assign restart  = start && (state == ST_DONE || state == ST_ERR);
  assign next_idx = word_idx + 1'b1;

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .byte_en   (asm_en),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_last (asm_last)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_acc;

  // Running XOR over every header and data byte of the current load.
  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      csum_acc <= '0;
    end else if (asm_en) begin
      csum_acc <= csum_acc ^ byte_data;
    end
  end
`endif

  // Load sequencer with registered handshake and CPU-memory write outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_HDR;
      word_count <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      init_en    <= 1'b0;
      init_data  <= '0;
      init_addr  <= ADDR_BASE;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        ST_HDR: begin
          byte_ready <= 1'b1;
          if (asm_last) begin
            if (asm_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state      <= ST_CSUM;
`else
              state      <= ST_DONE;
              byte_ready <= 1'b0;
              done       <= 1'b1;
              cpu_rst    <= 1'b0;
`endif
            end else if (asm_word > 32'(MAX_WORDS)) begin
              state      <= ST_ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              state      <= ST_DATA;
              word_count <= asm_word[IDX_W-1:0];
              word_idx   <= '0;
            end
          end
        end
        ST_DATA: begin
          if (asm_last) begin
            state      <= ST_WRITE;
            byte_ready <= 1'b0;
            init_en    <= 1'b1;
            init_data  <= asm_word;
            init_addr  <= word_addr(ADDR_BASE, 32'(word_idx));
          end
        end
        ST_WRITE: begin
          init_en  <= 1'b0;
          word_idx <= next_idx;
          if (next_idx == word_count) begin
`ifdef LOADER_CHECKSUM_EN
            state      <= ST_CSUM;
            byte_ready <= 1'b1;
`else
            state      <= ST_DONE;
            done       <= 1'b1;
            cpu_rst    <= 1'b0;
`endif
          end else begin
            state      <= ST_DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept) begin
            byte_ready <= 1'b0;
            if (byte_data == csum_acc) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        ST_DONE, ST_ERR: begin
          if (start) begin
            state      <= ST_HDR;
            word_count <= '0;
            word_idx   <= '0;
            byte_ready <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst    <= 1'b1;
          end
        end
        default: begin
          state      <= ST_HDR;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
